alu_exec: RTL and testbench

Registered execute unit that consumes the 4-bit `aluctl` code produced by the ALU control decoder and performs the selected operation on two operands. It sits in the execute stage of the multi-cycle core, between operand select and writeback. It uses a start/busy/done handshake so that shifts can run iteratively without stalling the decoder path. The zero flag feeds branch resolution.

---
 rtl/alu_exec.sv | 138 +++++++++++++
 tb/tb_alu_exec.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// alu_exec: registered execute-stage ALU with a start/busy/done handshake and an iterative SLL.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shift.
module alu_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       aluctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1100;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] op_result;
  logic             op_illegal;

  assign shamt = b[SHW-1:0];

  // Single-cycle datapath; for the iterative build SLL here only covers shamt == 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    op_result  = '0;
    op_illegal = 1'b0;
    case (aluctl)
      OP_AND: op_result = a & b;
      OP_OR:  op_result = a | b;
      OP_XOR: op_result = a ^ b;
      OP_ADD: op_result = a + b;
      OP_SUB: op_result = a - b;
      OP_SLT: op_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL: op_result = a << shamt;
`else
      OP_SLL: op_result = a;
`endif
      default: op_illegal = 1'b1;
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN

  assign busy = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      illegal <= 1'b0;
      result  <= '0;
      zero    <= 1'b1;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
      done    <= start;
      illegal <= start & op_illegal;
      if (start) begin
        result <= op_result;
        zero   <= (op_result == '0);
      end
    end
  end

`else

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc_shl;
  logic             is_sll;

  assign acc_shl = {acc[WIDTH-2:0], 1'b0};
  assign is_sll  = (aluctl == OP_SLL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      result  <= '0;
      zero    <= 1'b1;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_sll && (shamt != '0)) begin
              acc   <= a;
              cnt   <= shamt;
              busy  <= 1'b1;
              state <= SHIFT;
            end else begin
              result  <= op_result;
              zero    <= (op_result == '0);
              illegal <= op_illegal;
              done    <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // start is deliberately not looked at here: requests while busy are dropped.
          acc <= acc_shl;
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            result <= acc_shl;
            zero   <= (acc_shl == '0);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: scoreboard of expected completions checked by a done monitor.
// Honours ALU_FAST_SHIFT_EN so the same bench covers both shifter builds.
module tb_alu_exec;

  localparam int W = 32;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         start  = 1'b0;
  logic [3:0]   aluctl = 4'b0000;
  logic [W-1:0] a      = '0;
  logic [W-1:0] b      = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  alu_exec #(.WIDTH(W), .SHW(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .aluctl  (aluctl),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .zero    (zero),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the number of the rising edge just passed.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         ill;
    int           due;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Single-cycle ops complete after the accepting edge; an SLL by N completes N edges later.
  function automatic int sll_extra(input int n);
    return FAST ? 0 : n;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: done=1 at edge %0d result=%h, expected no completion", cyc, result);
      end else begin
        mon_e = sb.pop_front();
        if (result !== mon_e.res || zero !== mon_e.z || illegal !== mon_e.ill || cyc !== mon_e.due) begin
          n_fail++;
          $display("FAIL %s: got result=%h zero=%b illegal=%b edge=%0d, expected result=%h zero=%b illegal=%b edge=%0d",
                   mon_e.name, result, zero, illegal, cyc, mon_e.res, mon_e.z, mon_e.ill, mon_e.due);
        end
      end
    end
    if (rst_n && illegal && !done) begin
      n_checks++;
      n_fail++;
      $display("FAIL illegal_without_done: illegal=1 done=0 at edge %0d, expected illegal only with done", cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  // All tasks start and end at posedge+1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic issue(input string nm, input logic [3:0] ctl, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] er, input logic eill,
                       input int extra);
    aluctl = ctl;
    a      = av;
    b      = bv;
    start  = 1'b1;
    sb.push_back('{res: er, z: (er == '0), ill: eill, due: cyc + 1 + extra, name: nm});
    step();
    start = 1'b0;
  endtask

  task automatic drain(input string nm, input int bound, input int exp_busy);
    int n  = 0;
    int nb = 0;
    while (sb.size() != 0 && n < bound) begin
      if (busy) nb++;
      step();
      n++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d results outstanding after %0d cycles, expected 0", nm, sb.size(), n);
      sb.delete();
    end
    n_checks++;
    if (nb !== exp_busy) begin
      n_fail++;
      $display("FAIL %s_busy: busy high for %0d cycles, expected %0d", nm, nb, exp_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || illegal !== 1'b0 || result !== '0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b illegal=%b result=%h zero=%b, expected 0 0 0 00000000 1",
               busy, done, illegal, result, zero);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_logic();
    issue("and", 4'b0000, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0000, 1'b0, 0);
    drain("and", 10, 0);
    issue("or",  4'b0001, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0FFF, 1'b0, 0);
    drain("or", 10, 0);
    issue("xor", 4'b1100, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0FFF, 1'b0, 0);
    drain("xor", 10, 0);
    issue("add", 4'b0010, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0FFF, 1'b0, 0);
    drain("add", 10, 0);
  endtask

  task automatic test_arith();
    issue("sub_eq",   4'b0110, 32'd5,         32'd5,         32'h0000_0000, 1'b0, 0);
    drain("sub_eq", 10, 0);
    issue("slt_neg",  4'b0111, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 0);
    drain("slt_neg", 10, 0);
    issue("slt_pos",  4'b0111, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 0);
    drain("slt_pos", 10, 0);
    issue("sub_wrap", 4'b0110, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 0);
    drain("sub_wrap", 10, 0);
    issue("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0, 0);
    drain("add_wrap", 10, 0);
  endtask

  task automatic test_sll();
    issue("sll_4",  4'b0011, 32'd3, 32'd4,         32'h0000_0030, 1'b0, sll_extra(4));
    drain("sll_4", 40, sll_extra(4));
    issue("sll_0",  4'b0011, 32'd3, 32'd0,         32'h0000_0003, 1'b0, 0);
    drain("sll_0", 40, 0);
    issue("sll_hi", 4'b0011, 32'd3, 32'h0000_0124, 32'h0000_0030, 1'b0, sll_extra(4));
    drain("sll_hi", 40, sll_extra(4));
    issue("sll_31", 4'b0011, 32'd3, 32'd31,        32'h8000_0000, 1'b0, sll_extra(31));
    drain("sll_31", 60, sll_extra(31));
  endtask

  task automatic test_reset_mid_shift();
    int m  = cyc;
    int nd = 0;
    // Only the fast build finishes this shift before the reset lands.
    aluctl = 4'b0011;
    a      = 32'd1;
    b      = 32'd20;
    start  = 1'b1;
    if (FAST) sb.push_back('{res: 32'h0010_0000, z: 1'b0, ill: 1'b0, due: m + 1, name: "rst_fast_sll"});
    step();
    start = 1'b0;
    wait_to(m + 5);
    n_checks++;
    if (busy !== !FAST) begin
      n_fail++;
      $display("FAIL rst_mid_busy_before: busy=%b, expected %b", busy, !FAST);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || result !== '0 || zero !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_state: busy=%b result=%h zero=%b done=%b, expected 0 00000000 1 0",
               busy, result, zero, done);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (30) begin
      step();
      if (done) nd++;
    end
    n_checks++;
    if (nd !== 0 || sb.size() !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_no_done: %0d done pulses, %0d outstanding, expected 0 and 0", nd, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    int m = cyc;
    aluctl = 4'b0010;
    a      = 32'd1;
    b      = 32'd1;
    start  = 1'b1;
    sb.push_back('{res: 32'd2, z: 1'b0, ill: 1'b0, due: m + 1, name: "b2b_add"});
    step();
    aluctl = 4'b0110;
    a      = 32'd7;
    b      = 32'd2;
    sb.push_back('{res: 32'd5, z: 1'b0, ill: 1'b0, due: m + 2, name: "b2b_sub"});
    step();
    start = 1'b0;
    drain("b2b", 10, 0);
  endtask

  task automatic test_handshake();
    int k;
    aluctl = 4'b0011;
    a      = 32'd5;
    b      = 32'd8;
    start  = 1'b1;
    sb.push_back('{res: 32'h0000_0500, z: 1'b0, ill: 1'b0, due: cyc + 1 + 8, name: "hs_sll"});
    step();
    start = 1'b0;
    k = cyc;
    // ADD pulsed while busy must leave no trace.
    wait_to(k + 2);
    aluctl = 4'b0010;
    a      = 32'd1;
    b      = 32'd1;
    start  = 1'b1;
    step();
    start = 1'b0;
    // Held from before the done edge; first sampled while idle at edge k+9.
    wait_to(k + 7);
    aluctl = 4'b1100;
    a      = 32'h0000_00F0;
    b      = 32'h0000_0F0F;
    start  = 1'b1;
    sb.push_back('{res: 32'h0000_0FFF, z: 1'b0, ill: 1'b0, due: k + 9, name: "hs_held_xor"});
    step();
    step();
    start = 1'b0;
    drain("hs", 20, 0);
  endtask

  task automatic test_illegal();
    issue("illegal_f", 4'b1111, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0000, 1'b1, 0);
    drain("illegal_f", 10, 0);
    issue("and_nz",    4'b0000, 32'h0000_00FF, 32'h0000_0F0F, 32'h0000_000F, 1'b0, 0);
    drain("and_nz", 10, 0);
    issue("illegal_4", 4'b0100, 32'd1,         32'd1,         32'h0000_0000, 1'b1, 0);
    drain("illegal_4", 10, 0);
  endtask

  initial begin
    test_reset();
    test_logic();
    test_arith();
    test_sll();
    test_reset_mid_shift();
    test_back_to_back();
`ifndef ALU_FAST_SHIFT_EN
    test_handshake();
`endif
    test_illegal();
    repeat (3) step();
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d results outstanding, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
